calc_arbiter_service: RTL and testbench
=======================================

// Module: calc_arbiter_service
// PURPOSE
//  Multi-channel successor of the single-client calculator service. Arbitrates N_CH
//  requesters (round-robin) onto one floating-point operator via AXIS a/b/result
//  buses, honouring tready/tvalid and tagging each operation with tid = channel.
//  Adds a result-watchdog timeout and tid checking. Sits between DAC waveform
//  engines and the shared FP core.
// PARAMETERS
//  N_CH       4     number of requesting channels (2..16)
//  DATA_W     32    operand/result width (FP single)
//  TID_W      4     AXIS tid width; must satisfy 2**TID_W >= N_CH
//  TIMEOUT    1023  max cycles in WAIT_RES before abort (>=1)
// PORTS
//  aclk           in   1          clock
//  areset         in   1          synchronous reset, active-high
//  ch_start       in   N_CH       level request per channel
//  ch_a, ch_b     in   N_CH*DATA_W operands, channel i at [i*DATA_W +: DATA_W]
//  ch_busy        out  N_CH       request accepted, not yet completed
//  ch_done        out  N_CH       1-cycle completion pulse
//  ch_err         out  N_CH       sticky: last op of channel timed out; cleared on next grant
//  ch_result      out  N_CH*DATA_W last good result per channel (held)
//  a_tdata/b_tdata     out DATA_W ; a_tvalid/b_tvalid out 1 ; a_tready/b_tready in 1
//  a_tlast/b_tlast     out 1 (=tvalid) ; a_tid/b_tid out TID_W (granted channel)
//  result_tdata in DATA_W ; result_tvalid in 1 ; result_tid in TID_W ; result_tready out 1
//  tid_err        out  1          1-cycle pulse: result beat with unexpected tid dropped
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, rr pointer 0, per-channel armed=1, ch_result=0.
//  - Eligible(i) = ch_start[i] & armed[i]. armed[i] clears at done, sets when ch_start[i]=0.
//  - FSM IDLE->ISSUE->WAIT_RES->COMPLETE->IDLE.
//   IDLE: if any eligible, grant = first eligible at/after rr pointer; latch
//     ch_a/ch_b of grant into a_tdata/b_tdata, set ch_busy[grant], clear ch_err[grant].
//   ISSUE: a_tvalid/b_tvalid high (tlast=1, tid=grant); each drops independently
//     the cycle after its own tvalid&tready; data stable while valid. Both sent -> WAIT_RES.
//   WAIT_RES: result_tready=1 (registered, asserted on entry). Beat with
//     result_tid==grant -> ch_result[grant]<=result_tdata, ->COMPLETE. Beat with other
//     tid -> dropped, tid_err pulse, stay. Counter reaches TIMEOUT -> ch_err[grant]=1,
//     result not updated, ->COMPLETE.
//   COMPLETE: ch_done[grant] pulse, ch_busy[grant]<=0, armed[grant]<=0,
//     rr pointer<=grant+1 (wrap at N_CH), result_tready<=0, ->IDLE.
//  - Min latency start->done with ready operator: 4 cycles + operator latency.
//  - Channel dropping ch_start mid-op: op completes normally; no re-issue.
//  - Beat accepted in COMPLETE/IDLE impossible (tready=0); stray beats are not consumed.
//  - Illegal state -> IDLE (safe default), outputs deasserted.
//  - Reset mid-operation: all tvalid/tready drop next edge; in-flight op abandoned.
// STRUCTURE
//  - calc_pkg: state_e enum, calc_tid_t width helper, TIMEOUT default constant.
//  - Sub-module rr_arbiter (N_CH, req/ptr -> one-hot grant + index), combinational.
//  - Watchdog counter width $clog2(TIMEOUT+1), cleared on WAIT_RES entry.
// TESTING
//  1 ch0 start, a=3.0,b=2.0, op returns 5.0 tid0 after 6 cyc -> ch_done[0] pulse, ch_result[0]=5.0.
//  2 ch0..3 start together -> grants 0,1,2,3 in order; then ch1 re-arms -> served after ptr wraps.
//  3 a_tready held low 5 cycles, b_tready immediate -> b_tvalid 1 cycle, a_tdata stable, one beat each.
//  4 result beat tid=2 while grant=1 -> tid_err pulse, stay WAIT_RES; tid=1 beat then completes.
//  5 no result for TIMEOUT cycles -> ch_err set, ch_done pulse, ch_result unchanged; next grant clears err.
//  6 areset in ISSUE with tvalid high -> next cycle all tvalid/busy 0, state IDLE.

Source files
------------

// File: rtl/calc_arbiter_service_pkg.sv
// Shared types and defaults for the multi-channel calculator arbiter.
package calc_arbiter_service_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    COMPLETE = 2'd3
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1023;
  localparam int unsigned TID_W_DEFAULT   = 4;

  typedef logic [TID_W_DEFAULT-1:0] calc_tid_t;

  // Smallest index width that can name every channel.
  function automatic int unsigned calc_tid_w(input int unsigned n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/calc_arbiter_service_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module calc_arbiter_service_rr_arbiter
  import calc_arbiter_service_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned IDX_W = calc_tid_w(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [N_CH-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx
);

  int               w_pos;
  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest slot down so the closest requester is written last.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    w_pos   = 0;
    w_idx   = '0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= int'(N_CH)) w_pos = w_pos - int'(N_CH);
      w_idx = IDX_W'(w_pos);
      if (i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end

endmodule

// File: rtl/calc_arbiter_service.sv
// Round-robin service of N_CH calculator clients onto one shared AXIS floating-point operator.
module calc_arbiter_service
  import calc_arbiter_service_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TID_W   = TID_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  input  logic [N_CH-1:0]        i_ch_start,
  input  logic [N_CH*DATA_W-1:0] i_ch_a,
  input  logic [N_CH*DATA_W-1:0] i_ch_b,
  output logic [N_CH-1:0]        o_ch_busy,
  output logic [N_CH-1:0]        o_ch_done,
  output logic [N_CH-1:0]        o_ch_err,
  output logic [N_CH*DATA_W-1:0] o_ch_result,
  output logic [DATA_W-1:0]      o_a_tdata,
  output logic                   o_a_tvalid,
  input  logic                   i_a_tready,
  output logic                   o_a_tlast,
  output logic [TID_W-1:0]       o_a_tid,
  output logic [DATA_W-1:0]      o_b_tdata,
  output logic                   o_b_tvalid,
  input  logic                   i_b_tready,
  output logic                   o_b_tlast,
  output logic [TID_W-1:0]       o_b_tid,
  input  logic [DATA_W-1:0]      i_result_tdata,
  input  logic                   i_result_tvalid,
  input  logic [TID_W-1:0]       i_result_tid,
  output logic                   o_result_tready,
  output logic                   o_tid_err
);
  // state    | meaning
  // IDLE     | pick next eligible channel, latch its operands
  // ISSUE    | present a/b beats until each has handshaken
  // WAIT_RES | accept result beat for grant, watchdog running
  // COMPLETE | done pulse, release channel, advance rr pointer

  localparam int unsigned IDX_W  = calc_tid_w(N_CH);
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  state_e                  r_state, w_next;
  logic [IDX_W-1:0]        r_grant, r_ptr;
  logic [N_CH-1:0]         r_armed, r_busy, r_err;
  logic [N_CH*DATA_W-1:0]  r_result;
  logic [DATA_W-1:0]       r_a_tdata, r_b_tdata;
  logic                    r_a_tvalid, r_b_tvalid, r_res_tready, r_tid_err;
  logic [WDOG_W-1:0]       r_wdog;

  logic [N_CH-1:0]   w_req, w_arb_grant, w_grant_oh;
  logic [IDX_W-1:0]  w_arb_idx;
  logic              w_arb_valid, w_a_pend, w_b_pend, w_beat, w_good, w_bad, w_wdog_tc;
  logic [DATA_W-1:0] w_sel_a, w_sel_b;

  assign w_req      = i_ch_start & r_armed;
  assign w_grant_oh = N_CH'(1) << r_grant;
  assign w_a_pend   = r_a_tvalid & ~i_a_tready;
  assign w_b_pend   = r_b_tvalid & ~i_b_tready;
  assign w_beat     = i_result_tvalid & r_res_tready;
  assign w_good     = w_beat & (i_result_tid == TID_W'(r_grant));
  assign w_bad      = w_beat & (i_result_tid != TID_W'(r_grant));
  assign w_wdog_tc  = (r_wdog == WDOG_W'(TIMEOUT - 1));

  calc_arbiter_service_rr_arbiter #(.N_CH(N_CH)) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_valid (w_arb_valid),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (w_arb_grant[i]) begin
        w_sel_a = i_ch_a[i*DATA_W +: DATA_W];
        w_sel_b = i_ch_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_arb_valid) w_next = ISSUE;
      ISSUE:    if (!w_a_pend && !w_b_pend) w_next = WAIT_RES;
      WAIT_RES: if (w_good || w_wdog_tc) w_next = COMPLETE;
      COMPLETE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    o_ch_done = '0;
    if (r_state == COMPLETE) o_ch_done = w_grant_oh;
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_grant      <= '0;
      r_ptr        <= '0;
      r_armed      <= '1;
      r_busy       <= '0;
      r_err        <= '0;
      r_result     <= '0;
      r_a_tdata    <= '0;
      r_b_tdata    <= '0;
      r_a_tvalid   <= 1'b0;
      r_b_tvalid   <= 1'b0;
      r_res_tready <= 1'b0;
      r_tid_err    <= 1'b0;
      r_wdog       <= '0;
    end else begin
      r_armed      <= r_armed | ~i_ch_start;
      r_tid_err    <= 1'b0;
      r_res_tready <= (w_next == WAIT_RES);
      case (r_state)
        IDLE: if (w_arb_valid) begin
          r_grant    <= w_arb_idx;
          r_a_tdata  <= w_sel_a;
          r_b_tdata  <= w_sel_b;
          r_busy     <= r_busy | w_arb_grant;
          r_err      <= r_err & ~w_arb_grant;
          r_a_tvalid <= 1'b1;
          r_b_tvalid <= 1'b1;
        end
        ISSUE: begin
          if (r_a_tvalid && i_a_tready) r_a_tvalid <= 1'b0;
          if (r_b_tvalid && i_b_tready) r_b_tvalid <= 1'b0;
          r_wdog <= '0;
        end
        WAIT_RES: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_good) begin
            for (int i = 0; i < int'(N_CH); i++)
              if (w_grant_oh[i]) r_result[i*DATA_W +: DATA_W] <= i_result_tdata;
          end else if (w_wdog_tc) begin
            r_err <= r_err | w_grant_oh;
          end
          if (w_bad) r_tid_err <= 1'b1;
        end
        COMPLETE: begin
          r_busy  <= r_busy & ~w_grant_oh;
          r_armed <= (r_armed | ~i_ch_start) & ~w_grant_oh;
          r_ptr   <= (r_grant == IDX_W'(N_CH - 1)) ? '0 : r_grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ch_busy       = r_busy;
  assign o_ch_err        = r_err;
  assign o_ch_result     = r_result;
  assign o_a_tdata       = r_a_tdata;
  assign o_a_tvalid      = r_a_tvalid;
  assign o_a_tlast       = r_a_tvalid;
  assign o_a_tid         = r_a_tvalid ? TID_W'(r_grant) : '0;
  assign o_b_tdata       = r_b_tdata;
  assign o_b_tvalid      = r_b_tvalid;
  assign o_b_tlast       = r_b_tvalid;
  assign o_b_tid         = r_b_tvalid ? TID_W'(r_grant) : '0;
  assign o_result_tready = r_res_tready;
  assign o_tid_err       = r_tid_err;

endmodule

// File: tb/tb_calc_arbiter_service.sv
// Bench for calc_arbiter_service: vector table plus corner sequences, completions scoreboarded.
module tb_calc_arbiter_service;
  localparam int N_CH    = 4;
  localparam int DATA_W  = 32;
  localparam int TID_W   = 4;
  localparam int TIMEOUT = 20;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH-1:0]        i_ch_start = '0;
  logic [N_CH*DATA_W-1:0] i_ch_a = '0, i_ch_b = '0;
  logic [N_CH-1:0]        o_ch_busy, o_ch_done, o_ch_err;
  logic [N_CH*DATA_W-1:0] o_ch_result;
  logic [DATA_W-1:0]      o_a_tdata, o_b_tdata;
  logic                   o_a_tvalid, o_b_tvalid, o_a_tlast, o_b_tlast;
  logic                   i_a_tready = 1'b0, i_b_tready = 1'b0;
  logic [TID_W-1:0]       o_a_tid, o_b_tid;
  logic [DATA_W-1:0]      i_result_tdata = '0;
  logic                   i_result_tvalid = 1'b0;
  logic [TID_W-1:0]       i_result_tid = '0;
  logic                   o_result_tready, o_tid_err;

  calc_arbiter_service #(.N_CH(N_CH), .DATA_W(DATA_W), .TID_W(TID_W), .TIMEOUT(TIMEOUT)) dut (
    .i_aclk(clk), .i_areset(rst), .i_ch_start(i_ch_start), .i_ch_a(i_ch_a), .i_ch_b(i_ch_b),
    .o_ch_busy(o_ch_busy), .o_ch_done(o_ch_done), .o_ch_err(o_ch_err), .o_ch_result(o_ch_result),
    .o_a_tdata(o_a_tdata), .o_a_tvalid(o_a_tvalid), .i_a_tready(i_a_tready), .o_a_tlast(o_a_tlast),
    .o_a_tid(o_a_tid), .o_b_tdata(o_b_tdata), .o_b_tvalid(o_b_tvalid), .i_b_tready(i_b_tready),
    .o_b_tlast(o_b_tlast), .o_b_tid(o_b_tid), .i_result_tdata(i_result_tdata),
    .i_result_tvalid(i_result_tvalid), .i_result_tid(i_result_tid),
    .o_result_tready(o_result_tready), .o_tid_err(o_tid_err)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [31:0] res; logic err; } exp_t;
  typedef struct {
    int ch; logic [31:0] a; logic [31:0] b; logic [31:0] res;
    int lat; int a_st; int b_st; bit bad_tid; bit tmo;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  logic [31:0] last_res[N_CH];
  int          n_chk = 0, n_pass = 0, cyc_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && o_ch_done != '0) begin
      if (sb.size() == 0) chk("unexpected_done", 64'(o_ch_done), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("done_onehot", 64'(o_ch_done), 64'(1) << mon_e.ch);
        chk("result", 64'(o_ch_result[mon_e.ch*DATA_W +: DATA_W]), 64'(mon_e.res));
        chk("err_at_done", 64'(o_ch_err[mon_e.ch]), 64'(mon_e.err));
        chk("busy_at_done", 64'(o_ch_busy[mon_e.ch]), 64'd1);
      end
    end
  end

  task automatic serve(input int ch, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input int a_st, input int b_st,
                       input bit bad, input bit tmo, input bit chk_lat);
    int   t0, n, na, nb, va, vb, unstable, m;
    exp_t e;
    t0    = cyc_cnt;
    e.ch  = ch;
    e.res = tmo ? last_res[ch] : res;
    e.err = tmo;
    sb.push_back(e);
    n = 0;
    while (!o_a_tvalid && n < 40) begin tick(); n++; end
    chk("grant_seen", 64'(o_a_tvalid), 64'd1);
    chk("a_tid", 64'(o_a_tid), 64'(ch));
    chk("b_tid", 64'(o_b_tid), 64'(ch));
    chk("busy_set", 64'(o_ch_busy[ch]), 64'd1);
    chk("err_cleared_on_grant", 64'(o_ch_err[ch]), 64'd0);
    chk("a_tdata", 64'(o_a_tdata), 64'(a));
    chk("b_tdata", 64'(o_b_tdata), 64'(b));
    n = 0; na = 0; nb = 0; va = 0; vb = 0; unstable = 0;
    while ((o_a_tvalid || o_b_tvalid) && n < 40) begin
      i_a_tready = (n >= a_st);
      i_b_tready = (n >= b_st);
      if (o_a_tvalid) begin
        va++;
        if (o_a_tdata !== a || o_a_tlast !== 1'b1) unstable++;
        if (i_a_tready) na++;
      end
      if (o_b_tvalid) begin
        vb++;
        if (o_b_tdata !== b || o_b_tlast !== 1'b1) unstable++;
        if (i_b_tready) nb++;
      end
      tick(); n++;
    end
    i_a_tready = 1'b0;
    i_b_tready = 1'b0;
    chk("a_beats", 64'(na), 64'd1);
    chk("b_beats", 64'(nb), 64'd1);
    chk("a_valid_cycles", 64'(va), 64'(a_st + 1));
    chk("b_valid_cycles", 64'(vb), 64'(b_st + 1));
    chk("issue_data_stable", 64'(unstable), 64'd0);
    n = 0;
    while (!o_result_tready && n < 10) begin tick(); n++; end
    chk("res_tready", 64'(o_result_tready), 64'd1);
    m = (a_st > b_st) ? a_st : b_st;
    if (!tmo) begin
      repeat (lat) tick();
      if (bad) begin
        i_result_tvalid = 1'b1;
        i_result_tdata  = 32'hDEADBEEF;
        i_result_tid    = TID_W'((ch + 1) % N_CH);
        tick();
        i_result_tvalid = 1'b0;
        chk("tid_err_pulse", 64'(o_tid_err), 64'd1);
        chk("stay_wait_res", 64'(o_result_tready), 64'd1);
        chk("no_done_on_bad_tid", 64'(o_ch_done), 64'd0);
      end
      i_result_tvalid = 1'b1;
      i_result_tdata  = res;
      i_result_tid    = TID_W'(ch);
      tick();
      i_result_tvalid = 1'b0;
    end
    n = 0;
    while (o_ch_done == '0 && n < TIMEOUT + 20) begin tick(); n++; end
    chk("done_seen", 64'(o_ch_done != '0), 64'd1);
    if (chk_lat)
      chk("latency", 64'(cyc_cnt - t0), tmo ? 64'(2 + m + TIMEOUT) : 64'(3 + m + lat + int'(bad)));
    if (!tmo) last_res[ch] = res;
    tick();
    chk("busy_clear", 64'(o_ch_busy[ch]), 64'd0);
    chk("res_tready_low", 64'(o_result_tready), 64'd0);
    chk("err_sticky", 64'(o_ch_err[ch]), 64'(tmo));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < N_CH; i++) last_res[i] = '0;
    //           ch  a             b             res          lat a_st b_st bad  tmo
    vecs[0] = '{0, 32'h40400000, 32'h40000000, 32'h40A00000, 6, 0, 0, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h3FC00000, 32'h40200000, 32'h40800000, 2, 5, 0, 1'b0, 1'b0};
    vecs[2] = '{1, 32'h40E00000, 32'h40400000, 32'h41200000, 1, 0, 3, 1'b1, 1'b0};
    vecs[3] = '{2, 32'h41000000, 32'h3F800000, 32'h41100000, 0, 0, 0, 1'b0, 1'b0};
    vecs[4] = '{3, 32'h42200000, 32'h40000000, 32'h42280000, 3, 1, 2, 1'b0, 1'b0};
    vecs[5] = '{3, 32'h11111111, 32'h22222222, 32'h0,        0, 0, 0, 1'b0, 1'b1};
    vecs[6] = '{3, 32'h3F000000, 32'h3F000000, 32'h3F800000, 4, 2, 2, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(o_ch_busy), 64'd0);
    chk("rst_done", 64'(o_ch_done), 64'd0);
    chk("rst_err", 64'(o_ch_err), 64'd0);
    chk("rst_result", 64'(o_ch_result == '0), 64'd1);
    chk("rst_valid", 64'({o_a_tvalid, o_b_tvalid, o_result_tready, o_tid_err}), 64'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      i_ch_start[vecs[i].ch] = 1'b1;
      i_ch_a[vecs[i].ch*DATA_W +: DATA_W] = vecs[i].a;
      i_ch_b[vecs[i].ch*DATA_W +: DATA_W] = vecs[i].b;
      serve(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].a_st,
            vecs[i].b_st, vecs[i].bad_tid, vecs[i].tmo, 1'b1);
      i_ch_start[vecs[i].ch] = 1'b0;
      tick();
    end

    // all four request at once with the pointer at 0: served 0,1,2,3
    for (int k = 0; k < N_CH; k++) begin
      i_ch_a[k*DATA_W +: DATA_W] = 32'h40000000 + 32'(k);
      i_ch_b[k*DATA_W +: DATA_W] = 32'h40100000 + 32'(k);
    end
    i_ch_start = '1;
    for (int k = 0; k < N_CH; k++)
      serve(k, 32'h40000000 + 32'(k), 32'h40100000 + 32'(k), 32'h41000000 + 32'(k),
            1, 0, 0, 1'b0, 1'b0, 1'b0);
    i_ch_start[1] = 1'b0;
    tick();
    i_ch_start[1] = 1'b1;
    serve(1, 32'h40000001, 32'h40100001, 32'h41A00000, 2, 0, 0, 1'b0, 1'b0, 1'b1);
    i_ch_start = '0;
    tick();

    // reset while operands are still being presented
    i_ch_start[2] = 1'b1;
    n = 0;
    while (!o_a_tvalid && n < 20) begin tick(); n++; end
    chk("pre_rst_valid", 64'(o_a_tvalid & o_b_tvalid), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_a_tvalid", 64'(o_a_tvalid), 64'd0);
    chk("rst_mid_b_tvalid", 64'(o_b_tvalid), 64'd0);
    chk("rst_mid_busy", 64'(o_ch_busy), 64'd0);
    chk("rst_mid_tready", 64'(o_result_tready), 64'd0);
    chk("rst_mid_result", 64'(o_ch_result == '0), 64'd1);
    i_ch_start[2] = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_after_rst", 64'({o_a_tvalid, o_ch_busy}), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
